// File: rtl/gate_test_sequencer.sv
// Drives up to NUM_PAIRS input pairs into a 2-input gate and captures its synchronised output per pair.
// Latency: done asserts NUM_PAIRS*(SETTLE_CYCLES+1)+1 cycles after start is accepted.
// No backpressure: start is honoured only in IDLE and never queued. abort cancels a running test.
// Optional GATE_SEQ_STABILITY_CHECK_EN adds the unstable output.
module gate_test_sequencer #(
  parameter int NUM_PAIRS     = 4,
  parameter int SETTLE_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] vec_in,
  input  logic [3:0] expected,
  input  logic       dut_out,
  output logic [1:0] dut_pinout,
  output logic       dut_drive,
  output logic [1:0] pair_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] mismatch
`ifdef GATE_SEQ_STABILITY_CHECK_EN
  ,
  output logic [3:0] unstable
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0]       PAIR_MASK = 4'((1 << NUM_PAIRS) - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(NUM_PAIRS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [7:0]       vec_q;
  logic [3:0]       exp_q;
  logic             sync1_q, dut_sync;
  logic [3:0]       result_q, mismatch_q;
  logic             pass_q;
  logic [3:0]       result_nxt, mismatch_nxt;
  logic             pass_nxt;
  logic             accept;

  assign accept = (state_q == IDLE) && start && !abort;

  // dut_out is asynchronous to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      dut_sync <= 1'b0;
    end else begin
      sync1_q  <= dut_out;
      dut_sync <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   if (abort) state_d = IDLE;
               else if (cnt_q == '0) state_d = SAMPLE;
      SAMPLE:  if (abort) state_d = IDLE;
               else if (idx_q == LAST_IDX) state_d = DONE;
               else state_d = DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef GATE_SEQ_STABILITY_CHECK_EN
  logic       last_sync_q;
  logic [3:0] unstable_q, unstable_nxt;

  always_comb begin
    unstable_nxt = unstable_q;
    if (last_sync_q != dut_sync) unstable_nxt[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_sync_q <= 1'b0;
      unstable_q  <= 4'b0;
    end else begin
      if (state_q == DRIVE && cnt_q == '0) last_sync_q <= dut_sync;
      if (accept || (abort && (state_q == DRIVE || state_q == SAMPLE)))
        unstable_q <= 4'b0;
      else if (state_q == SAMPLE)
        unstable_q <= unstable_nxt;
    end
  end

  assign unstable = unstable_q;
`endif

  // Final pass/mismatch are formed from the last capture so they are valid during done
  always_comb begin
    result_nxt         = result_q;
    result_nxt[idx_q]  = dut_sync;
    mismatch_nxt       = (result_nxt ^ exp_q) & PAIR_MASK;
`ifdef GATE_SEQ_STABILITY_CHECK_EN
    pass_nxt           = (mismatch_nxt == 4'b0) && (unstable_nxt == 4'b0);
`else
    pass_nxt           = (mismatch_nxt == 4'b0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'b0;
      vec_q      <= 8'b0;
      exp_q      <= 4'b0;
      result_q   <= 4'b0;
      mismatch_q <= 4'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          vec_q      <= vec_in;
          exp_q      <= expected;
          result_q   <= 4'b0;
          mismatch_q <= 4'b0;
          pass_q     <= 1'b0;
          idx_q      <= 2'b0;
          cnt_q      <= CNT_LOAD;
        end
        DRIVE, SAMPLE: if (abort) begin
          result_q   <= 4'b0;
          mismatch_q <= 4'b0;
          pass_q     <= 1'b0;
          idx_q      <= 2'b0;
        end else if (state_q == DRIVE) begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end else begin
          result_q <= result_nxt;
          if (idx_q == LAST_IDX) begin
            mismatch_q <= mismatch_nxt;
            pass_q     <= pass_nxt;
          end else begin
            idx_q <= idx_q + 2'd1;
            cnt_q <= CNT_LOAD;
          end
        end
        DONE:    idx_q <= 2'b0;
        default: idx_q <= 2'b0;
      endcase
    end
  end

  assign dut_drive  = (state_q == DRIVE) || (state_q == SAMPLE);
  assign dut_pinout = dut_drive ? vec_q[{idx_q, 1'b0} +: 2] : 2'b00;
  assign pair_idx   = idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign result     = result_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer with a behavioural gate model on dut_out.
module tb_gate_test_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] vec_in = 8'b0;
  logic [3:0] expected = 4'b0;
  logic       dut_out;
  logic [1:0] dut_pinout;
  logic       dut_drive;
  logic [1:0] pair_idx;
  logic       busy, done, pass;
  logic [3:0] result, mismatch;
`ifdef GATE_SEQ_STABILITY_CHECK_EN
  logic [3:0] unstable;
`endif

  // model: 0 stuck-0, 1 AND, 2 XOR
  logic [1:0] model = 2'd1;
  logic       flip = 1'b0;
  assign dut_out = ((model == 2'd1) ? (&dut_pinout) :
                    (model == 2'd2) ? (^dut_pinout) : 1'b0) ^ flip;

  gate_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vec_in(vec_in), .expected(expected), .dut_out(dut_out),
    .dut_pinout(dut_pinout), .dut_drive(dut_drive), .pair_idx(pair_idx),
    .busy(busy), .done(done), .pass(pass), .result(result), .mismatch(mismatch)
`ifdef GATE_SEQ_STABILITY_CHECK_EN
    , .unstable(unstable)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic [1:0] pins_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic log_pins();
    if (dut_drive && (pins_log.size() == 0 || pins_log[pins_log.size()-1] != dut_pinout))
      pins_log.push_back(dut_pinout);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    log_pins();
  endtask

  task automatic run_until(input int n);
    while (cyc < n) tick();
  endtask

  // Acceptance edge ends cycle 0; afterwards the bench sits in cycle 1
  task automatic start_test(input logic [7:0] v, input logic [3:0] e);
    vec_in = v;
    expected = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    done_cnt = 0;
    done_cyc = -1;
    pins_log.delete();
    log_pins();
  endtask

  initial begin
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_pins", dut_pinout, 0);
    check("reset_drive", dut_drive, 0);
    check("reset_outs", {done, pass, result, mismatch, pair_idx}, 0);
    rst = 1'b0;
    tick();

    // abort wins over simultaneous start in IDLE
    start = 1'b1; abort = 1'b1; vec_in = 8'hE4;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 0);

    // 1: AND gate, full truth table
    model = 2'd1;
    start_test(8'b11100100, 4'b1000);
    check("t1_busy_c1", busy, 1);
    check("t1_drive_c1", dut_drive, 1);
    run_until(420);
    check("t1_done_cycle", done_cyc, 405);
    check("t1_done_count", done_cnt, 1);
    check("t1_pass", pass, 1);
    check("t1_result", result, 4'b1000);
    check("t1_mismatch", mismatch, 4'b0000);
    check("t1_pin_count", pins_log.size(), 4);
    for (int i = 0; i < 4 && i < pins_log.size(); i++)
      check($sformatf("t1_pins%0d", i), pins_log[i], i);
    check("t1_idle_after", {busy, dut_drive, dut_pinout}, 0);

    // 2: stuck-at-0 gate
    model = 2'd0;
    start_test(8'b11100100, 4'b1000);
    run_until(420);
    check("t2_done_cycle", done_cyc, 405);
    check("t2_pass", pass, 0);
    check("t2_result", result, 4'b0000);
    check("t2_mismatch", mismatch, 4'b1000);

    // 3: abort mid-test, then clean rerun
    model = 2'd1;
    start_test(8'b11100100, 4'b1000);
    run_until(150);
    check("t3_busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_pins", dut_pinout, 0);
    check("t3_drive", dut_drive, 0);
    check("t3_cleared", {pass, result, mismatch}, 0);
    run_until(600);
    check("t3_no_done", done_cnt, 0);
    start_test(8'b11100100, 4'b1000);
    run_until(420);
    check("t3_rerun_done", done_cyc, 405);
    check("t3_rerun_pass", pass, 1);

    // 4: start while busy is ignored, new vec_in not latched
    start_test(8'b11100100, 4'b1000);
    run_until(200);
    start = 1'b1; vec_in = 8'h00; expected = 4'h0;
    tick();
    start = 1'b0;
    run_until(420);
    check("t4_done_count", done_cnt, 1);
    check("t4_done_cycle", done_cyc, 405);
    check("t4_result", result, 4'b1000);
    check("t4_pass", pass, 1);
    check("t4_idle", busy, 0);

    // 5: reset mid-test
    start_test(8'b11100100, 4'b1000);
    run_until(250);
    rst = 1'b1;
    tick();
    check("t5_outs", {dut_pinout, dut_drive, pair_idx, busy, done, pass, result, mismatch}, 0);
    rst = 1'b0;
    run_until(700);
    check("t5_no_done", done_cnt, 0);
    check("t5_idle", busy, 0);

`ifdef GATE_SEQ_STABILITY_CHECK_EN
    // 6: XOR gate, output glitches in last settle cycle of pair 2
    model = 2'd2;
    start_test(8'b11100100, 4'b0110);
    run_until(301);
    flip = 1'b1;
    tick();
    flip = 1'b0;
    run_until(420);
    check("t6_done_cycle", done_cyc, 405);
    check("t6_unstable", unstable, 4'b0100);
    check("t6_pass", pass, 0);
    check("t6_result", result, 4'b0010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
